// File: rtl/note_recorder.sv
// Record/playback sequencer: samples the key note into a small buffer once per slot
// while recording and replays it slot by slot while playing.
module note_recorder #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        value_input,
  input  logic              rec_btn,
  input  logic              play_btn,
  output logic              state,
  output logic [2:0]        value_play,
  output logic              rec_led,
  output logic [ADDR_W:0]   len
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W:0] LEN_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECORD,
    S_PLAY
  } fsm_t;

  fsm_t              r_fsm, w_fsm_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W:0]   r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [2:0]        r_value_play, w_value_play_nxt;
  logic              r_state, r_rec_led;
  logic [2:0]        r_mem [DEPTH];

  logic              w_tick;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [2:0]        w_rd_data;

  assign w_tick    = (r_fsm != S_IDLE) && (r_cnt == CNT_LAST);
  // IDLE reads slot 0 for PLAY entry; PLAY looks one slot ahead of ptr.
  assign w_rd_addr = (r_fsm == S_PLAY) ? ADDR_W'(r_ptr + 1'b1) : '0;
  assign w_rd_data = r_mem[w_rd_addr];

  // NOTE: every signal written here gets a default first so no latch is inferred;
  // combinational logic uses blocking (=) assignments.
  always_comb begin
    w_fsm_nxt        = r_fsm;
    w_len_nxt        = r_len;
    w_ptr_nxt        = r_ptr;
    w_value_play_nxt = r_value_play;
    w_mem_we         = 1'b0;

    unique case (r_fsm)
      S_IDLE: begin
        if (rec_btn) begin
          w_fsm_nxt = S_RECORD;
          w_len_nxt = '0;
        end else if (play_btn && (r_len != '0)) begin
          w_fsm_nxt        = S_PLAY;
          w_ptr_nxt        = '0;
          w_value_play_nxt = w_rd_data;
        end
      end

      S_RECORD: begin
        if (w_tick) begin
          w_mem_we  = 1'b1;
          w_len_nxt = r_len + 1'b1;
          if (r_len == LEN_LAST) w_fsm_nxt = S_IDLE;
        end
        if (rec_btn) w_fsm_nxt = S_IDLE;
      end

      S_PLAY: begin
        if (play_btn) begin
          w_fsm_nxt        = S_IDLE;
          w_value_play_nxt = 3'd0;
        end else if (w_tick) begin
          if ({1'b0, r_ptr} == (r_len - 1'b1)) begin
            w_fsm_nxt        = S_IDLE;
            w_value_play_nxt = 3'd0;
          end else begin
            w_ptr_nxt        = r_ptr + 1'b1;
            w_value_play_nxt = w_rd_data;
          end
        end
      end

      default: begin
        w_fsm_nxt        = S_IDLE;
        w_value_play_nxt = 3'd0;
      end
    endcase

    if ((w_fsm_nxt != r_fsm) || (r_fsm == S_IDLE) || w_tick)
      w_cnt_nxt = '0;
    else
      w_cnt_nxt = r_cnt + 1'b1;
  end

  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm        <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_ptr        <= '0;
      r_value_play <= 3'd0;
      r_state      <= 1'b0;
      r_rec_led    <= 1'b0;
    end else begin
      r_fsm        <= w_fsm_nxt;
      r_cnt        <= w_cnt_nxt;
      r_len        <= w_len_nxt;
      r_ptr        <= w_ptr_nxt;
      r_value_play <= w_value_play_nxt;
      r_state      <= (w_fsm_nxt == S_PLAY);
      r_rec_led    <= (w_fsm_nxt == S_RECORD);
    end
  end

  // NOTE: the buffer has no reset so it maps onto distributed RAM; len alone
  // decides which slots are valid.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_len[ADDR_W-1:0]] <= value_input;
  end

  assign state      = r_state;
  assign value_play = r_value_play;
  assign rec_led    = r_rec_led;
  assign len        = r_len;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with DEPTH=4, TICK_DIV=4.
module tb_note_recorder;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int TICK_DIV = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      value_input = 3'd0;
  logic            rec_btn = 1'b0;
  logic            play_btn = 1'b0;
  logic            state;
  logic [2:0]      value_play;
  logic            rec_led;
  logic [ADDR_W:0] len;

  int n_checks = 0;
  int n_errors = 0;

  note_recorder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_input(value_input),
    .rec_btn    (rec_btn),
    .play_btn   (play_btn),
    .state      (state),
    .value_play (value_play),
    .rec_led    (rec_led),
    .len        (len)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs change 1 time unit after an edge and are sampled by the next edge.
  task automatic pulse(input logic rec, input logic play);
    rec_btn  = rec;
    play_btn = play;
    @(posedge clk);
    #1;
    rec_btn  = 1'b0;
    play_btn = 1'b0;
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(1);
  endtask

  task automatic test_reset();
    do_reset();
    chk("reset state", int'(state), 0);
    chk("reset value_play", int'(value_play), 0);
    chk("reset rec_led", int'(rec_led), 0);
    chk("reset len", int'(len), 0);
    // asynchronous reset applied between edges while recording
    pulse(1'b1, 1'b0);
    chk("rec entry rec_led", int'(rec_led), 1);
    #3 rst = 1'b1;
    #1;
    chk("async rst rec_led", int'(rec_led), 0);
    chk("async rst state", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(1);
    chk("after async rst rec_led", int'(rec_led), 0);
  endtask

  task automatic test_record();
    pulse(1'b1, 1'b0);
    chk("record entry rec_led", int'(rec_led), 1);
    chk("record entry len", int'(len), 0);
    for (int s = 1; s <= 3; s++) begin
      value_input = 3'(s);
      wait_cycles(3);
      chk("record len before tick", int'(len), s - 1);
      wait_cycles(1);
      chk("record len after tick", int'(len), s);
    end
    value_input = 3'd0;
    pulse(1'b1, 1'b0);
    chk("record stop rec_led", int'(rec_led), 0);
    chk("record stop len", int'(len), 3);
  endtask

  task automatic test_playback();
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk("play state", int'(state), 1);
      chk("play value", int'(value_play), i / 4 + 1);
      wait_cycles(1);
    end
    chk("play end state", int'(state), 0);
    chk("play end value", int'(value_play), 0);
    chk("play end len", int'(len), 3);
  endtask

  task automatic test_full();
    value_input = 3'd5;
    pulse(1'b1, 1'b0);
    chk("full entry len", int'(len), 0);
    wait_cycles(15);
    chk("full c15 rec_led", int'(rec_led), 1);
    chk("full c15 len", int'(len), 3);
    wait_cycles(1);
    chk("full c16 rec_led", int'(rec_led), 0);
    chk("full c16 len", int'(len), 4);
    wait_cycles(8);
    chk("full hold len", int'(len), 4);
    value_input = 3'd0;
    pulse(1'b0, 1'b1);
    chk("full play value first", int'(value_play), 5);
    wait_cycles(15);
    chk("full play value last", int'(value_play), 5);
    chk("full play state last", int'(state), 1);
    wait_cycles(1);
    chk("full play end state", int'(state), 0);
  endtask

  task automatic test_corner();
    do_reset();
    pulse(1'b0, 1'b1);
    chk("play len0 state", int'(state), 0);
    wait_cycles(2);
    chk("play len0 state later", int'(state), 0);
    value_input = 3'd7;
    pulse(1'b1, 1'b1);
    chk("both btn rec_led", int'(rec_led), 1);
    chk("both btn state", int'(state), 0);
    pulse(1'b0, 1'b1);
    chk("play in record rec_led", int'(rec_led), 1);
    chk("play in record state", int'(state), 0);
    wait_cycles(15);
    chk("corner full rec_led", int'(rec_led), 0);
    chk("corner full len", int'(len), 4);
    value_input = 3'd0;
    pulse(1'b0, 1'b1);
    chk("corner play value", int'(value_play), 7);
    wait_cycles(2);
    pulse(1'b1, 1'b0);
    chk("rec in play state", int'(state), 1);
    chk("rec in play rec_led", int'(rec_led), 0);
    wait_cycles(1);
    pulse(1'b0, 1'b1);
    chk("stop play state", int'(state), 0);
    chk("stop play value", int'(value_play), 0);
    chk("stop play len", int'(len), 4);
  endtask

  task automatic test_reset_mid_play();
    pulse(1'b0, 1'b1);
    chk("mid play entry state", int'(state), 1);
    wait_cycles(5);
    chk("mid play slot2 value", int'(value_play), 7);
    #2 rst = 1'b1;
    #1;
    chk("mid play rst state", int'(state), 0);
    chk("mid play rst len", int'(len), 0);
    chk("mid play rst value", int'(value_play), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(1);
    pulse(1'b0, 1'b1);
    chk("play after rst state", int'(state), 0);
    chk("play after rst len", int'(len), 0);
  endtask

  initial begin
    test_reset();
    test_record();
    test_playback();
    test_full();
    test_corner();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
